// File: rtl/tug_pkg.sv
// Shared tug-of-war definitions: player FSM states, LFSR geometry, HEX winner glyphs.
// Used by the cyber player, the lfsr10 generator and the playfield display logic.
package tug_pkg;

  localparam int LFSR_WIDTH = 10;
  // x^10 + x^7 + 1 taps, expressed as bit indices of the shift register
  localparam int LFSR_TAP_HI = 9;
  localparam int LFSR_TAP_LO = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2
  } player_state_t;

  // Active-low seven-segment patterns, bit order gfedcba
  localparam logic [6:0] HEX_OFF   = 7'b1111111;
  localparam logic [6:0] HEX_LEFT  = 7'b1000111;
  localparam logic [6:0] HEX_RIGHT = 7'b0101111;

  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] s);
    return {s[LFSR_WIDTH-2:0], ~(s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO])};
  endfunction

endpackage

// File: rtl/lfsr10.sv
// Step-enabled 10-bit Fibonacci XNOR LFSR; all-zero reset state, all-ones is the unreachable lockup.
// One step per cycle with step high; no backpressure.
module lfsr10
  import tug_pkg::*;
(
  input  logic                  CLOCK_50,
  input  logic                  rst_n,
  input  logic                  step,
  output logic [LFSR_WIDTH-1:0] q
);

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (step) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/cyber_player.sv
// Computer tug-of-war opponent: LFSR-vs-threshold press decisions on a prescaled tick.
// pull rises one clock after the deciding tick; no backpressure, enable=0 freezes to IDLE.
module cyber_player
  import tug_pkg::*;
#(
  parameter int LFSR_W     = LFSR_WIDTH,
  parameter int TICK_MAX   = 49999,
  parameter int HOLD_TICKS = 4,
  parameter int GAP_TICKS  = 2
) (
  input  logic              CLOCK_50,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [LFSR_W-1:0] threshold,
  output logic              pressed,
  output logic              pull,
  output logic              tick
);

  localparam int TW = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
  localparam int CW = $clog2(((HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS) + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_MAX);

  logic [TW-1:0]     tick_cnt;
  logic [LFSR_W-1:0] lfsr;
  logic              hit;
  player_state_t     state, state_nxt;
  logic [CW-1:0]     hold_cnt, hold_nxt;
  logic [CW-1:0]     gap_cnt, gap_nxt;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  lfsr10 u_lfsr (
    .CLOCK_50 (CLOCK_50),
    .rst_n    (rst_n),
    .step     (tick),
    .q        (lfsr)
  );

  // Decision uses the value held before this tick's LFSR step
  assign hit = (lfsr < threshold);

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    gap_nxt   = gap_cnt;
    if (!enable) begin
      state_nxt = IDLE;
      hold_nxt  = '0;
      gap_nxt   = '0;
    end else if (tick) begin
      unique case (state)
        IDLE: begin
          if (hit) begin
            state_nxt = HOLD;
            hold_nxt  = CW'(HOLD_TICKS);
          end
        end
        HOLD: begin
          hold_nxt = hold_cnt - CW'(1);
          if (hold_cnt == CW'(1)) begin
            state_nxt = RELEASE;
            gap_nxt   = CW'(GAP_TICKS);
          end
        end
        RELEASE: begin
          gap_nxt = gap_cnt - CW'(1);
          if (gap_cnt == CW'(1)) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      pressed  <= 1'b0;
      pull     <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      gap_cnt  <= gap_nxt;
      pressed  <= (state_nxt == HOLD);
      pull     <= (state == IDLE) && (state_nxt == HOLD);
    end
  end

endmodule

// File: doc/cyber_player.md
Name: cyber_player

Overview:
- Computer opponent for the tug-of-war game.
- Emulates one human player: a debounced button level plus a single-cycle pull pulse, in the same form the button-press conditioning stage delivers to the light chain.
- Press decisions are pseudo-random. An LFSR is compared against a difficulty threshold on a slow prescaled tick.
- Sits between the board switches (difficulty) and the L/R pull input of the playfield, replacing one KEY-driven press stage.

Parameters:
- LFSR_W, 10, LFSR and threshold width.
- TICK_MAX, 49999, prescaler terminal count; one decision tick every TICK_MAX+1 clocks (1 kHz at 50 MHz).
- HOLD_TICKS, 4, ticks the emulated button stays pressed; must be ≥1.
- GAP_TICKS, 2, minimum released ticks before the next press; must be ≥1.

Ports:
- Clock  input  1  system clock (CLOCK_50 at top).
- Reset  input  1  asynchronous, active-low reset.
- enable  input  1  1 = game running; 0 = player frozen (game over / paused).
- threshold  input  LFSR_W  difficulty; larger value gives more frequent presses.
- pressed  output  1  emulated button level, high while held.
- pull  output  1  one-cycle pulse per press, aligned to the first pressed cycle.
- tick  output  1  prescaler strobe, exported for debug and bench sync.

Behaviour:
- Reset (Reset=0, async): tick_cnt=0, lfsr=0, state=IDLE, hold/gap counters=0, pressed=0, pull=0. Reset mid-press aborts immediately; there is no pull on release of reset.
- Prescaler:
  - tick_cnt counts 0..TICK_MAX, wraps to 0.
  - tick=1 combinationally when tick_cnt==TICK_MAX.
  - Runs regardless of enable.
- LFSR:
  - Fibonacci, polynomial x^10+x^7+1, XNOR feedback.
  - On tick: lfsr <= {lfsr[8:0], ~(lfsr[9]^lfsr[6])}.
  - All-ones (1023) is the lockup state and is never reached from reset.
  - Sequence from reset: 0,1,3,7,15,31,63,127,254,...
  - Advances on every tick, including when enable=0.
- Decision: hit = (lfsr < threshold), unsigned, using the lfsr value before that tick's step.
  - threshold=0 never hits.
  - threshold=1023 hits on every reachable value.
- FSM states IDLE, HOLD, RELEASE:
  - IDLE: on tick & enable & hit -> HOLD, and load hold counter with HOLD_TICKS.
  - HOLD: on each tick decrement the counter. On the tick where the counter reaches 0 -> RELEASE, and load gap counter with GAP_TICKS.
  - RELEASE: on each tick decrement. On the tick where it reaches 0 -> IDLE.
  - Any state with enable=0 -> IDLE next edge; counters are cleared.
- Outputs are registered:
  - pressed = (state==HOLD).
  - pull is high for exactly the first cycle of HOLD.
  - pull is never high on consecutive cycles.
  - pull is never high while enable was low on the previous edge.
- Cadence: the minimum spacing between pulls is HOLD_TICKS+GAP_TICKS+1 ticks. With threshold=1023 this spacing is exact.
- Latency: pull rises 1 clock after the deciding tick cycle.

Decomposition:
- Shared package tug_pkg:
  - state enum (IDLE, HOLD, RELEASE).
  - LFSR_W default.
  - LFSR tap constants.
  - HEX winner-pattern constants, also used by the playfield.
- One natural sub-module: lfsr10, the step-enabled XNOR LFSR with async active-low reset. It is reusable for other random stimulus on the board.
- Prescaler and FSM stay in cyber_player.

Test Plan:
- Reset sequence:
  - Stimulus: Reset=0 mid-HOLD, then release.
  - Required: pressed=0 and pull=0 immediately while Reset=0; lfsr=0 and tick_cnt=0 after release; no spurious pull.
- LFSR order:
  - Stimulus: TICK_MAX=3, enable=0, run 9 ticks.
  - Required: lfsr reads 0,1,3,7,15,31,63,127,254 at successive ticks; pressed and pull stay 0 throughout.
- Never-press case:
  - Stimulus: TICK_MAX=3, threshold=0, enable=1, run 2000 clocks.
  - Required: pull never asserts; pressed stays 0.
- Max-rate case:
  - Stimulus: TICK_MAX=3, threshold=1023, enable=1, HOLD_TICKS=4, GAP_TICKS=2.
  - Required:
    - First tick is at cycle 3.
    - pull=1 at cycle 4 only.
    - pressed=1 for 16 cycles.
    - Subsequent pulls exactly every 28 cycles.
- Threshold boundary:
  - Stimulus: TICK_MAX=3, threshold=1.
  - Required: hit on the first tick (lfsr=0). After cooldown, no hit on the following ticks (lfsr values 7,15,31,... are ≥1) until lfsr returns to 0.
- Enable drop mid-HOLD:
  - Stimulus: deassert enable during the second tick of HOLD.
  - Required:
    - pressed falls on the next clock.
    - No pull while enable=0.
    - After re-enable, the next pull needs a new hit.
